// File: rtl/mem_port_arbiter_pkg.sv
// Shared arbiter state encodings for the IF/MEM unified memory port.
package mem_port_arbiter_pkg;

  localparam int ARB_STATE_W = 3;

  typedef enum logic [ARB_STATE_W-1:0] {
    ARB_IDLE     = 3'd0,
    ARB_BUSY_IF  = 3'd1,
    ARB_BUSY_MEM = 3'd2,
    ARB_RESP_IF  = 3'd3,
    ARB_RESP_MEM = 3'd4
  } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle watchdog: a down-counter reloaded while idle, expiring on terminal count.
module arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT);
  // Loaded with TIMEOUT-2 so the terminal count falls on busy cycle TIMEOUT-1.
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 2);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = run & (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter sharing one variable-latency memory port between IF and MEM.
//
// state        | meaning
// ARB_IDLE     | no access in flight; samples requests, MEM wins ties
// ARB_BUSY_IF  | instruction read on the port, waiting for ram_ack or watchdog
// ARB_BUSY_MEM | load/store on the port, waiting for ram_ack or watchdog
// ARB_RESP_IF  | port released; ack IF if it still asks for the latched address
// ARB_RESP_MEM | port released; ack MEM if it still asks for the latched access
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              mem_stall,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dout,
  input  logic [DATA_W-1:0] ram_din,
  input  logic              ram_ack,
  output logic              bus_err
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
  logic              bus_err_q;
  logic              mem_req, busy, wd_expire;

  assign mem_req = mem_ren | mem_wen;
  assign busy    = (state_q == ARB_BUSY_IF) || (state_q == ARB_BUSY_MEM);

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (~busy),
    .run    (busy),
    .expire (wd_expire)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (mem_req)     state_d = ARB_BUSY_MEM;
        else if (if_req) state_d = ARB_BUSY_IF;
      end
      ARB_BUSY_IF:  if (ram_ack || wd_expire) state_d = ARB_RESP_IF;
      ARB_BUSY_MEM: if (ram_ack || wd_expire) state_d = ARB_RESP_MEM;
      ARB_RESP_IF,
      ARB_RESP_MEM: state_d = ARB_IDLE;
      default:      state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB_IDLE) begin
        if (mem_req) begin
          addr_q  <= mem_addr;
          wdata_q <= mem_wdata;
          we_q    <= mem_wen;
        end else if (if_req) begin
          addr_q  <= if_addr;
          wdata_q <= '0;
          we_q    <= 1'b0;
        end
      end
      // A real ack beats a simultaneous watchdog expiry.
      if (busy && ram_ack) begin
        if (state_q == ARB_BUSY_IF) begin
          if_rdata_q <= ram_din;
        end else if (!we_q) begin
          mem_rdata_q <= ram_din;
        end
      end else if (busy && wd_expire) begin
        bus_err_q <= 1'b1;
        if (state_q == ARB_BUSY_IF) begin
          if_rdata_q <= '0;
        end else begin
          mem_rdata_q <= '0;
        end
      end
    end
  end

  // A requester that moved on (e.g. a flushed fetch) no longer matches and gets no ack.
  assign if_ack    = (state_q == ARB_RESP_IF) && if_req && (if_addr == addr_q);
  assign mem_ack   = (state_q == ARB_RESP_MEM) && mem_req && (mem_addr == addr_q) &&
                     (mem_wen == we_q);
  assign if_stall  = if_req & ~if_ack;
  assign mem_stall = mem_req & ~mem_ack;

  assign ram_cs    = busy;
  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_dout  = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed timing cases, then randomized IF/MEM traffic against a memory model.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack, if_stall;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, mem_stall;
  logic        ram_cs, ram_we;
  logic [31:0] ram_addr, ram_dout, ram_din;
  logic        ram_ack;
  logic        bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .if_stall  (if_stall),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .mem_stall (mem_stall),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .ram_din   (ram_din),
    .ram_ack   (ram_ack),
    .bus_err   (bus_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, want %08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b, want %0b", name, act, exp);
    end
  endtask

  task automatic drive_pt();
    @(posedge clk);
    #1;
  endtask

  // Memory model: acks after ram_delay extra busy cycles, never while ram_hang.
  logic [31:0] ram_arr [256];
  logic [31:0] ref_mem [256];
  int  ram_delay = 0;
  int  ram_cnt   = 0;
  bit  ram_hang  = 1'b0;
  bit  ram_rand  = 1'b0;

  initial begin
    ram_ack = 1'b0;
    ram_din = '0;
    forever begin
      @(posedge clk);
      #1;
      if (ram_cs && !ram_hang && (ram_cnt >= ram_delay)) begin
        ram_ack = 1'b1;
        if (ram_we) ram_arr[ram_addr[9:2]] = ram_dout;
        else        ram_din = ram_arr[ram_addr[9:2]];
        ram_cnt = 0;
        if (ram_rand) ram_delay = $urandom_range(0, 4);
      end else begin
        ram_ack = 1'b0;
        ram_cnt = ram_cs ? ram_cnt + 1 : 0;
      end
    end
  end

  // Scoreboard: expected responses in issue order, popped on each ack.
  logic [31:0] exp_if [$];
  logic [31:0] exp_mem [$];
  bit          sb_on = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (sb_on) begin
        if (if_ack) begin
          if (exp_if.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_if_ack: got unexpected ack, want none");
          end else begin
            check("sb_if_rdata", if_rdata, exp_if.pop_front());
          end
        end
        if (mem_ack) begin
          if (exp_mem.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_mem_ack: got unexpected ack, want none");
          end else begin
            check("sb_mem_rdata", mem_rdata, exp_mem.pop_front());
          end
        end
      end
    end
  end

  // Called at a drive point; returns at the negedge of the ack cycle.
  task automatic wait_ack(input string name, input bit is_mem, input int budget,
                          input bit chk_store, input logic [31:0] exp_dout, input bit chk_ifst,
                          output int busy_n, output logic [31:0] first_addr);
    bit got;
    got = 1'b0;
    busy_n = 0;
    first_addr = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (ram_cs) begin
        if (busy_n == 0) first_addr = ram_addr;
        busy_n++;
        if (chk_store) begin
          check1({name, "_ram_we"}, ram_we, 1'b1);
          check({name, "_ram_dout"}, ram_dout, exp_dout);
        end
      end
      if (chk_ifst) check1({name, "_if_stall"}, if_stall, 1'b1);
      if (is_mem ? mem_ack : if_ack) begin
        got = 1'b1;
        break;
      end
      drive_pt();
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got no ack within %0d cycles, want ack", name, budget);
    end
  endtask

  bit          last_load_valid;
  logic [31:0] last_load;

  task automatic if_drv(input int n);
    int idx, flush_at;
    bit done;
    for (int i = 0; i < n; i++) begin
      if_req = 1'b0;
      repeat ($urandom_range(0, 2)) drive_pt();
      idx = $urandom_range(0, 63);
      if_req  = 1'b1;
      if_addr = 32'(idx) << 2;
      exp_if.push_back(ref_mem[idx]);
      flush_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge clk);
        if (if_ack) begin
          done = 1'b1;
        end else if (c == flush_at) begin
          done = 1'b1;
          exp_if.delete(exp_if.size() - 1);
        end else begin
          drive_pt();
        end
      end
      if (!done) begin
        n_cmp++; n_bad++;
        $display("FAIL rnd_if_wait: got no ack for %08h, want ack", if_addr);
        exp_if.delete(exp_if.size() - 1);
      end
      drive_pt();
    end
    if_req = 1'b0;
  endtask

  task automatic mem_drv(input int n);
    int idx, kind;
    logic [31:0] wd;
    bit done;
    for (int i = 0; i < n; i++) begin
      mem_ren = 1'b0;
      mem_wen = 1'b0;
      repeat ($urandom_range(1, 4)) drive_pt();
      idx  = $urandom_range(128, 255);
      kind = $urandom_range(0, 2);
      mem_addr = 32'(idx) << 2;
      if (kind == 0) begin
        mem_ren = 1'b1;
        exp_mem.push_back(ref_mem[idx]);
        last_load = ref_mem[idx];
      end else begin
        // Store; kind 2 also raises mem_ren, which must still act as a store.
        wd = $urandom;
        mem_wen   = 1'b1;
        mem_ren   = (kind == 2);
        mem_wdata = wd;
        ref_mem[idx] = wd;
        exp_mem.push_back(last_load);
      end
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge clk);
        if (mem_ack) done = 1'b1;
        else         drive_pt();
      end
      if (!done) begin
        n_cmp++; n_bad++;
        $display("FAIL rnd_mem_wait: got no ack for %08h, want ack", mem_addr);
        exp_mem.delete(exp_mem.size() - 1);
      end
      drive_pt();
    end
    mem_ren = 1'b0;
    mem_wen = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int          bn;
    logic [31:0] fa;
    int          diffs;

    for (int i = 0; i < 256; i++) ram_arr[i] = $urandom;
    ram_arr[64]  = 32'h2008_0005;
    ram_arr[65]  = 32'h1111_2222;
    ram_arr[16]  = 32'hCAFE_F00D;
    ram_arr[128] = 32'h2020_2020;
    ram_arr[192] = 32'h3030_3030;
    ram_arr[19]  = 32'h4C4C_4C4C;

    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (3) drive_pt();
    rst = 1'b0;
    @(negedge clk);
    check1("rst_ram_cs", ram_cs, 1'b0);
    check1("rst_if_ack", if_ack, 1'b0);
    check1("rst_mem_ack", mem_ack, 1'b0);
    check1("rst_bus_err", bus_err, 1'b0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);

    // Minimum-latency fetch.
    drive_pt();
    ram_delay = 0;
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    check1("t1_c0_ram_cs", ram_cs, 1'b0);
    check1("t1_c0_if_stall", if_stall, 1'b1);
    drive_pt();
    @(negedge clk);
    check1("t1_c1_ram_cs", ram_cs, 1'b1);
    check("t1_c1_ram_addr", ram_addr, 32'h100);
    check1("t1_c1_ram_we", ram_we, 1'b0);
    check1("t1_c1_if_stall", if_stall, 1'b1);
    check1("t1_c1_if_ack", if_ack, 1'b0);
    drive_pt();
    @(negedge clk);
    check1("t1_c2_if_ack", if_ack, 1'b1);
    check("t1_c2_if_rdata", if_rdata, 32'h2008_0005);
    check1("t1_c2_if_stall", if_stall, 1'b0);
    check1("t1_c2_ram_cs", ram_cs, 1'b0);
    drive_pt();
    if_req = 1'b0;

    // Simultaneous requests: MEM first, one IDLE cycle, then IF.
    drive_pt();
    ram_delay = 3;
    if_req = 1'b1; if_addr = 32'h104;
    mem_ren = 1'b1; mem_addr = 32'h40;
    wait_ack("t2_mem", 1'b1, 20, 1'b0, 32'h0, 1'b1, bn, fa);
    check("t2_mem_first_addr", fa, 32'h40);
    check("t2_mem_busy_cycles", 32'(bn), 32'd4);
    check("t2_mem_rdata", mem_rdata, 32'hCAFE_F00D);
    drive_pt();
    mem_ren = 1'b0;
    @(negedge clk);
    check1("t2_idle_ram_cs", ram_cs, 1'b0);
    check1("t2_idle_if_stall", if_stall, 1'b1);
    drive_pt();
    wait_ack("t2_if", 1'b0, 20, 1'b0, 32'h0, 1'b0, bn, fa);
    check("t2_if_first_addr", fa, 32'h104);
    check("t2_if_rdata", if_rdata, 32'h1111_2222);
    drive_pt();
    if_req = 1'b0;

    // Store: strobe and data held for every select cycle, load data untouched.
    drive_pt();
    ram_delay = 2;
    mem_wen = 1'b1; mem_addr = 32'h44; mem_wdata = 32'hDEAD_BEEF;
    wait_ack("t3_store", 1'b1, 20, 1'b1, 32'hDEAD_BEEF, 1'b0, bn, fa);
    check("t3_busy_cycles", 32'(bn), 32'd3);
    check("t3_mem_rdata_held", mem_rdata, 32'hCAFE_F00D);
    check("t3_ram_written", ram_arr[17], 32'hDEAD_BEEF);
    drive_pt();
    mem_wen = 1'b0;

    // Flushed fetch to 0x200 must not ack; the refetch at 0x300 must.
    drive_pt();
    ram_delay = 3;
    if_req = 1'b1; if_addr = 32'h200;
    drive_pt();
    drive_pt();
    if_req = 1'b0;
    drive_pt();
    if_req = 1'b1; if_addr = 32'h300;
    wait_ack("t4_refetch", 1'b0, 30, 1'b0, 32'h0, 1'b0, bn, fa);
    check("t4_if_rdata", if_rdata, 32'h3030_3030);
    check("t4_busy_cycles", 32'(bn), 32'd6);
    drive_pt();
    if_req = 1'b0;

    // Hung memory: watchdog abort after TIMEOUT-1 busy cycles, sticky error.
    drive_pt();
    ram_hang = 1'b1;
    mem_ren = 1'b1; mem_addr = 32'h48;
    wait_ack("t5_timeout", 1'b1, 30, 1'b0, 32'h0, 1'b0, bn, fa);
    check("t5_busy_cycles", 32'(bn), 32'(TO - 1));
    check("t5_mem_rdata", mem_rdata, 32'h0);
    check1("t5_bus_err", bus_err, 1'b1);
    drive_pt();
    mem_ren = 1'b0;
    ram_hang = 1'b0;
    ram_delay = 0;
    if_req = 1'b1; if_addr = 32'h100;
    wait_ack("t5_after", 1'b0, 20, 1'b0, 32'h0, 1'b0, bn, fa);
    check("t5_after_if_rdata", if_rdata, 32'h2008_0005);
    check1("t5_bus_err_sticky", bus_err, 1'b1);
    drive_pt();
    if_req = 1'b0;

    // Reset in the middle of a MEM access.
    drive_pt();
    ram_hang = 1'b1;
    mem_ren = 1'b1; mem_addr = 32'h4C;
    drive_pt();
    drive_pt();
    rst = 1'b1;
    drive_pt();
    @(negedge clk);
    check1("t6_ram_cs", ram_cs, 1'b0);
    check1("t6_mem_ack", mem_ack, 1'b0);
    check1("t6_if_ack", if_ack, 1'b0);
    check1("t6_bus_err", bus_err, 1'b0);
    check("t6_mem_rdata", mem_rdata, 32'h0);
    drive_pt();
    rst = 1'b0;
    ram_hang = 1'b0;
    ram_delay = 0;
    wait_ack("t6_retry", 1'b1, 20, 1'b0, 32'h0, 1'b0, bn, fa);
    check("t6_retry_rdata", mem_rdata, 32'h4C4C_4C4C);
    drive_pt();
    mem_ren = 1'b0;

    // Randomized traffic from a clean reset.
    drive_pt();
    rst = 1'b1;
    drive_pt();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = ram_arr[i];
    last_load_valid = 1'b1;
    last_load = 32'h0;
    ram_rand = 1'b1;
    ram_delay = $urandom_range(0, 4);
    sb_on = 1'b1;
    fork
      if_drv(150);
      mem_drv(150);
    join
    repeat (4) drive_pt();
    sb_on = 1'b0;
    check("rnd_if_left", 32'(exp_if.size()), 32'd0);
    check("rnd_mem_left", 32'(exp_mem.size()), 32'd0);
    check1("rnd_bus_err", bus_err, 1'b0);
    diffs = 0;
    for (int i = 128; i < 256; i++) if (ram_arr[i] !== ref_mem[i]) diffs++;
    check("rnd_mem_image_diffs", 32'(diffs), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
